// File: rtl/l2todr_req_arb_pkg.sv
// Shared L2-to-directory request/snack types and widths.
// nid is the lowest field of both payloads so nid[0] is always bit 0.
package l2todr_req_arb_pkg;

    localparam int NID_W   = 5;
    localparam int CMD_W   = 3;
    localparam int PADDR_W = 40;
    localparam int SNACK_W = 4;
    localparam int LINE_W  = 32;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [CMD_W-1:0]   cmd;
        logic [NID_W-1:0]   nid;
    } I_l2todr_req_type;

    typedef struct packed {
        logic [LINE_W-1:0]  line;
        logic [SNACK_W-1:0] snack;
        logic [NID_W-1:0]   nid;
    } I_drtol2_snack_type;

    localparam int REQ_W       = $bits(I_l2todr_req_type);
    localparam int SNACK_PKT_W = $bits(I_drtol2_snack_type);

    typedef enum logic {
        GNT_L2    = 1'b0,
        GNT_L2TLB = 1'b1
    } grant_e;

endpackage

// File: rtl/l2todr_req_fifo2.sv
// Two-entry valid/retry FIFO; input retry depends only on the registered count.
module l2todr_req_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_retry,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_retry,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [WIDTH-1:0] mem [2];
    logic             push;
    logic             pop;

    assign in_retry  = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && !in_retry;
    assign pop       = out_valid && !out_retry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/l2todr_req_arb.sv
// Round-robin merge of L2 and L2TLB requests toward the directory, plus
// nid-parity demux of directory snacks back to the two requesters.
module l2todr_req_arb
    import l2todr_req_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   l2_req_valid,
    output logic                   l2_req_retry,
    input  logic [REQ_W-1:0]       l2_req,

    input  logic                   l2tlb_req_valid,
    output logic                   l2tlb_req_retry,
    input  logic [REQ_W-1:0]       l2tlb_req,

    output logic                   l2todr_req_valid,
    input  logic                   l2todr_req_retry,
    output logic [REQ_W-1:0]       l2todr_req,

    input  logic                   drtol2_snack_valid,
    output logic                   drtol2_snack_retry,
    input  logic [SNACK_PKT_W-1:0] drtol2_snack,

    output logic                   l2_snack_valid,
    input  logic                   l2_snack_retry,
    output logic [SNACK_PKT_W-1:0] l2_snack,

    output logic                   l2tlb_snack_valid,
    input  logic                   l2tlb_snack_retry,
    output logic [SNACK_PKT_W-1:0] l2tlb_snack
);

    grant_e           last_grant;
    logic             fifo_full;
    logic             both_valid;
    logic             l2_wins;
    logic             tlb_wins;
    logic             grant_l2;
    logic             grant_tlb;
    logic             push_valid;
    logic [REQ_W-1:0] push_data;
    logic             snack_to_tlb;

    always_comb begin
        both_valid = l2_req_valid && l2tlb_req_valid;
        // On a tie the requester granted last time yields.
        l2_wins    = !(both_valid && (last_grant == GNT_L2));
        tlb_wins   = !(both_valid && (last_grant == GNT_L2TLB));
        grant_l2   = l2_req_valid && !fifo_full && l2_wins;
        grant_tlb  = l2tlb_req_valid && !fifo_full && tlb_wins;
        push_valid = grant_l2 || grant_tlb;
        push_data  = grant_l2 ? l2_req : l2tlb_req;
        l2_req_retry    = !reset && (fifo_full || !l2_wins);
        l2tlb_req_retry = !reset && (fifo_full || !tlb_wins);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_L2TLB;
        end else if (grant_l2) begin
            last_grant <= GNT_L2;
        end else if (grant_tlb) begin
            last_grant <= GNT_L2TLB;
        end
    end

    l2todr_req_fifo2 #(
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_retry  (fifo_full),
        .in_data   (push_data),
        .out_valid (l2todr_req_valid),
        .out_retry (l2todr_req_retry),
        .out_data  (l2todr_req)
    );

    // nid is the lowest payload field, so bit 0 is nid[0].
    assign snack_to_tlb       = drtol2_snack[0];
    assign l2_snack_valid     = drtol2_snack_valid && !snack_to_tlb;
    assign l2tlb_snack_valid  = drtol2_snack_valid && snack_to_tlb;
    assign drtol2_snack_retry = snack_to_tlb ? l2tlb_snack_retry : l2_snack_retry;
    assign l2_snack           = drtol2_snack;
    assign l2tlb_snack        = drtol2_snack;

endmodule

// File: tb/tb_l2todr_req_arb.sv
// Scoreboard bench for l2todr_req_arb: directed stimulus pushes expected
// payloads, a monitor pops and compares on every output transfer.
module tb_l2todr_req_arb;
    import l2todr_req_arb_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   l2_req_valid, l2_req_retry;
    logic [REQ_W-1:0]       l2_req;
    logic                   l2tlb_req_valid, l2tlb_req_retry;
    logic [REQ_W-1:0]       l2tlb_req;
    logic                   l2todr_req_valid, l2todr_req_retry;
    logic [REQ_W-1:0]       l2todr_req;
    logic                   drtol2_snack_valid, drtol2_snack_retry;
    logic [SNACK_PKT_W-1:0] drtol2_snack;
    logic                   l2_snack_valid, l2_snack_retry;
    logic [SNACK_PKT_W-1:0] l2_snack;
    logic                   l2tlb_snack_valid, l2tlb_snack_retry;
    logic [SNACK_PKT_W-1:0] l2tlb_snack;

    logic [REQ_W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l2todr_req_arb dut (
        .clk                (clk),
        .reset              (reset),
        .l2_req_valid       (l2_req_valid),
        .l2_req_retry       (l2_req_retry),
        .l2_req             (l2_req),
        .l2tlb_req_valid    (l2tlb_req_valid),
        .l2tlb_req_retry    (l2tlb_req_retry),
        .l2tlb_req          (l2tlb_req),
        .l2todr_req_valid   (l2todr_req_valid),
        .l2todr_req_retry   (l2todr_req_retry),
        .l2todr_req         (l2todr_req),
        .drtol2_snack_valid (drtol2_snack_valid),
        .drtol2_snack_retry (drtol2_snack_retry),
        .drtol2_snack       (drtol2_snack),
        .l2_snack_valid     (l2_snack_valid),
        .l2_snack_retry     (l2_snack_retry),
        .l2_snack           (l2_snack),
        .l2tlb_snack_valid  (l2tlb_snack_valid),
        .l2tlb_snack_retry  (l2tlb_snack_retry),
        .l2tlb_snack        (l2tlb_snack)
    );

    function automatic logic [REQ_W-1:0] mk_req(input logic [NID_W-1:0] nid,
                                                input logic [PADDR_W-1:0] paddr);
        I_l2todr_req_type r;
        r.paddr = paddr;
        r.cmd   = 3'd1;
        r.nid   = nid;
        return r;
    endfunction

    function automatic logic [SNACK_PKT_W-1:0] mk_snack(input logic [NID_W-1:0] nid,
                                                        input logic [LINE_W-1:0] line);
        I_drtol2_snack_type s;
        s.line  = line;
        s.snack = 4'h5;
        s.nid   = nid;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the drive edge, well clear of posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (l2todr_req_valid && !l2todr_req_retry) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %0h expected none", l2todr_req);
                    end else begin
                        chk("req_out", l2todr_req, exp_q.pop_front());
                    end
                end
                if (l2_req_valid && !l2_req_retry)
                    chk("l2_nid_parity", {63'd0, l2_req[0]}, 64'd0);
                if (l2tlb_req_valid && !l2tlb_req_retry)
                    chk("tlb_nid_parity", {63'd0, l2tlb_req[0]}, 64'd1);
            end
        end
    end

    initial begin
        logic             l2_turn;
        int               li, ti;
        logic [SNACK_PKT_W-1:0] sn;

        l2_req_valid = 1'b1;  l2_req = mk_req(5'h02, 40'h1);
        l2tlb_req_valid = 1'b1; l2tlb_req = mk_req(5'h03, 40'h2);
        l2todr_req_retry = 1'b0;
        drtol2_snack_valid = 1'b0; drtol2_snack = '0;
        l2_snack_retry = 1'b0; l2tlb_snack_retry = 1'b0;

        // Reset state, with both requesters valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, l2todr_req_valid}, 64'd0);
        chk("rst_l2_retry", {63'd0, l2_req_retry}, 64'd0);
        chk("rst_tlb_retry", {63'd0, l2tlb_req_retry}, 64'd0);
        l2_req_valid = 1'b0; l2tlb_req_valid = 1'b0;
        reset = 1'b0;

        // Round-robin over 6 tied cycles, L2 first
        l2_turn = 1'b1; li = 0; ti = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            l2_req_valid = 1'b1;
            l2_req = mk_req(5'(2 + 2 * li), 40'(16'h100 + li));
            l2tlb_req_valid = 1'b1;
            l2tlb_req = mk_req(5'(3 + 2 * ti), 40'(16'h200 + ti));
            #1;
            chk("rr_l2_retry", {63'd0, l2_req_retry}, {63'd0, !l2_turn});
            chk("rr_tlb_retry", {63'd0, l2tlb_req_retry}, {63'd0, l2_turn});
            if (l2_turn) begin
                exp_q.push_back(l2_req);
                li++;
            end else begin
                exp_q.push_back(l2tlb_req);
                ti++;
            end
            l2_turn = !l2_turn;
        end
        @(negedge clk);
        l2_req_valid = 1'b0; l2tlb_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, one-cycle latency
        #1;
        chk("idle_out_valid", {63'd0, l2todr_req_valid}, 64'd0);
        @(negedge clk);
        l2_req_valid = 1'b1; l2_req = mk_req(5'h10, 40'h1000);
        #1;
        chk("single_l2_retry", {63'd0, l2_req_retry}, 64'd0);
        exp_q.push_back(l2_req);
        @(negedge clk);
        l2_req_valid = 1'b0;
        #1;
        chk("lat1_valid", {63'd0, l2todr_req_valid}, 64'd1);
        chk("lat1_nid", {59'd0, l2todr_req[NID_W-1:0]}, 64'h10);

        // Backpressure: two fill the FIFO, third retried until a slot opens
        @(negedge clk);
        l2todr_req_retry = 1'b1;
        l2_req_valid = 1'b1; l2_req = mk_req(5'h08, 40'h3000);
        #1;
        chk("bp_p0_retry", {63'd0, l2_req_retry}, 64'd0);
        exp_q.push_back(l2_req);
        @(negedge clk);
        l2_req = mk_req(5'h0a, 40'h3001);
        #1;
        chk("bp_p1_retry", {63'd0, l2_req_retry}, 64'd0);
        exp_q.push_back(l2_req);
        @(negedge clk);
        l2_req = mk_req(5'h0c, 40'h3002);
        #1;
        chk("bp_full_retry", {63'd0, l2_req_retry}, 64'd1);
        @(negedge clk);
        #1;
        chk("bp_hold_retry", {63'd0, l2_req_retry}, 64'd1);
        chk("bp_head_nid", {59'd0, l2todr_req[NID_W-1:0]}, 64'h08);
        @(negedge clk);
        l2todr_req_retry = 1'b0;
        #1;
        chk("bp_pop_cycle_retry", {63'd0, l2_req_retry}, 64'd1);
        @(negedge clk);
        #1;
        chk("bp_p2_retry", {63'd0, l2_req_retry}, 64'd0);
        exp_q.push_back(l2_req);
        @(negedge clk);
        l2_req_valid = 1'b0;

        // Snack demux
        drtol2_snack_valid = 1'b1;
        sn = mk_snack(5'h07, 32'hcafe0007);
        drtol2_snack = sn;
        l2tlb_snack_retry = 1'b1; l2_snack_retry = 1'b0;
        #1;
        chk("sn7_tlb_valid", {63'd0, l2tlb_snack_valid}, 64'd1);
        chk("sn7_l2_valid", {63'd0, l2_snack_valid}, 64'd0);
        chk("sn7_retry", {63'd0, drtol2_snack_retry}, 64'd1);
        chk("sn7_payload", 64'(l2tlb_snack), 64'(sn));
        sn = mk_snack(5'h06, 32'hbeef0006);
        drtol2_snack = sn;
        #1;
        chk("sn6_l2_valid", {63'd0, l2_snack_valid}, 64'd1);
        chk("sn6_tlb_valid", {63'd0, l2tlb_snack_valid}, 64'd0);
        chk("sn6_retry", {63'd0, drtol2_snack_retry}, 64'd0);
        chk("sn6_payload", 64'(l2_snack), 64'(sn));
        l2_snack_retry = 1'b1; l2tlb_snack_retry = 1'b0;
        #1;
        chk("sn6_retry_on", {63'd0, drtol2_snack_retry}, 64'd1);
        drtol2_snack_valid = 1'b0;
        l2_snack_retry = 1'b0;

        // Reset with a full FIFO drops both entries
        @(negedge clk);
        l2todr_req_retry = 1'b1;
        l2_req_valid = 1'b1; l2_req = mk_req(5'h0e, 40'h4000);
        @(negedge clk);
        l2_req = mk_req(5'h12, 40'h4001);
        @(negedge clk);
        l2_req_valid = 1'b0;
        #1;
        chk("pre_rst_valid", {63'd0, l2todr_req_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, l2todr_req_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        l2todr_req_retry = 1'b0;
        #1;
        chk("post_rst_valid0", {63'd0, l2todr_req_valid}, 64'd0);
        @(negedge clk);
        #1;
        chk("post_rst_valid1", {63'd0, l2todr_req_valid}, 64'd0);
        @(negedge clk);
        l2_req_valid = 1'b1; l2_req = mk_req(5'h14, 40'h5000);
        l2tlb_req_valid = 1'b1; l2tlb_req = mk_req(5'h15, 40'h5001);
        #1;
        chk("rst_tie_l2_retry", {63'd0, l2_req_retry}, 64'd0);
        chk("rst_tie_tlb_retry", {63'd0, l2tlb_req_retry}, 64'd1);
        exp_q.push_back(l2_req);
        @(negedge clk);
        l2_req_valid = 1'b0;
        #1;
        chk("rst_tlb_retry2", {63'd0, l2tlb_req_retry}, 64'd0);
        exp_q.push_back(l2tlb_req);
        @(negedge clk);
        l2tlb_req_valid = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        #3;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2todr_req_arb.md
L2TODR_REQ_ARB -- requirements
Module: l2todr_req_arb

Interface
REQ-001 Parameters: none; all widths come from scmem.vh types.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 l2_req_valid  in  1  L2 request to directory.
REQ-005 l2_req_retry  out  1  backpressure to L2.
REQ-006 l2_req  in  $bits(I_l2todr_req_type)  L2 payload; nid[0]==0.
REQ-007 l2tlb_req_valid  in  1  L2TLB request to directory.
REQ-008 l2tlb_req_retry  out  1  backpressure to L2TLB.
REQ-009 l2tlb_req  in  $bits(I_l2todr_req_type)  L2TLB payload; nid[0]==1.
REQ-010 l2todr_req_valid  out  1  merged request to directory.
REQ-011 l2todr_req_retry  in  1  directory backpressure.
REQ-012 l2todr_req  out  $bits(I_l2todr_req_type)  merged payload.
REQ-013 drtol2_snack_valid / drtol2_snack_retry / drtol2_snack  in/out/in  1/1/$bits(I_drtol2_snack_type)  directory response.
REQ-014 l2_snack_valid / l2_snack_retry / l2_snack  out/in/out  1/1/$bits(I_drtol2_snack_type)  even-nid response to L2.
REQ-015 l2tlb_snack_valid / l2tlb_snack_retry / l2tlb_snack  out/in/out  1/1/$bits(I_drtol2_snack_type)  odd-nid response to L2TLB.

Function
REQ-016 Transfer on any channel occurs in a cycle with valid=1 and retry=0; the sender holds payload stable while valid=1 and retry=1.
REQ-017 Request path: 2-entry FIFO (count 0..2, 1-bit wrapping rd/wr pointers) between arbiter and l2todr_req.
REQ-018 Arbiter accepts at most one request per cycle, only when count<2.
REQ-019 Only one requester valid: it wins; both valid: the requester not granted last wins (round-robin).
REQ-020 last_grant register updates only on an accepted request; reset value = L2TLB, so L2 wins the first tie.
REQ-021 Loser, or any requester while count==2, sees retry=1; winner sees retry=0.
REQ-022 Accepted payload written unmodified to FIFO; l2todr_req_valid=1 from next cycle (latency 1 cycle, empty FIFO).
REQ-023 l2todr_req_valid = (count!=0); l2todr_req = head entry.
REQ-024 Pop when l2todr_req_valid && !l2todr_req_retry; push and pop in same cycle leave count unchanged, order preserved.
REQ-025 count==2 with pop that cycle: requesters still retried (retry depends on registered count only, no combinational path from l2todr_req_retry).
REQ-026 Snack path combinational demux on drtol2_snack.nid[0]: 0 -> L2, 1 -> L2TLB; only the selected output valid, other valid=0.
REQ-027 drtol2_snack_retry = retry of the selected target; payload fanned unmodified to both outputs.
REQ-028 Bench-only assertion: accepted l2_req with nid[0]==1 or l2tlb_req with nid[0]==0 is an error; RTL forwards unchanged.

Reset
REQ-029 While reset=1: count=0, pointers=0, last_grant=L2TLB, l2todr_req_valid=0, l2_req_retry=0, l2tlb_req_retry=0.
REQ-030 Snack outputs follow inputs combinationally during reset (no state).
REQ-031 Reset mid-operation discards FIFO contents; no payload emitted after deassertion until a new request is accepted.

Structure
REQ-032 I_l2todr_req_type, I_drtol2_snack_type and nid-parity encoding live in scmem.vh; no new types in this module.
REQ-033 FIFO is one sub-module, l2todr_req_fifo2 (2 entries, parameterised width, valid/retry both sides); arbiter and snack demux stay in the top module.

Verification
REQ-034 Only L2 valid, nid=0x10, empty FIFO, retry=0 -> l2todr_req_valid=1 next cycle, nid=0x10, l2_req_retry=0.
REQ-035 Both valid every cycle for 6 cycles, no backpressure -> output nid order L2,TLB,L2,TLB,L2,TLB; loser retried each cycle.
REQ-036 l2todr_req_retry=1 held, 3 requests offered -> 2 accepted, third retried while count==2; release -> drained in accept order, third accepted the cycle after count<2.
REQ-037 drtol2_snack nid=0x07 with l2tlb_snack_retry=1 -> l2tlb_snack_valid=1, l2_snack_valid=0, drtol2_snack_retry=1; nid=0x06 -> routed to L2.
REQ-038 Reset asserted with count==2 -> l2todr_req_valid=0 immediately; after deassertion first tie grants L2.
